// File: rtl/charmap_renderer_pkg.sv
// Shared definitions for the character-map renderer: register map, pipeline depth
// and the 8-bit attribute to RGB888 expansion.
package charmap_renderer_pkg;

    localparam int LATENCY = 3;

    localparam logic [2:0] REG_SCROLL_X_LO = 3'd0;
    localparam logic [2:0] REG_SCROLL_X_HI = 3'd1;
    localparam logic [2:0] REG_SCROLL_Y_LO = 3'd2;
    localparam logic [2:0] REG_SCROLL_Y_HI = 3'd3;
    localparam logic [2:0] REG_BG_COLOR    = 3'd4;
    localparam logic [2:0] REG_CTRL        = 3'd5;

    // Attribute layout {B[7:6],G[5:3],R[2:0]}; each field is replicated to fill the top 6 bits.
    function automatic logic [23:0] attr_to_rgb(input logic [7:0] a);
        return {a[2:0], a[2:0], 2'b00,
                a[5:3], a[5:3], 2'b00,
                a[7:6], a[7:6], a[7:6], 2'b00};
    endfunction

endpackage

// File: rtl/charmap_renderer_if.sv
// Register-write and external memory fetch bus of the renderer.
// master = renderer side (drives fetch addresses), slave = CPU/memory side.
interface charmap_renderer_if #(
    parameter int MAP_W = 11
);
    logic             reg_wr;
    logic [2:0]       reg_addr;
    logic [7:0]       reg_data;
    logic [MAP_W-1:0] map_addr;
    logic [7:0]       chram_q;
    logic [7:0]       colram_q;
    logic [10:0]      chrom_addr;
    logic [7:0]       chrom_q;

    modport master (
        input  reg_wr, reg_addr, reg_data, chram_q, colram_q, chrom_q,
        output map_addr, chrom_addr
    );

    modport slave (
        output reg_wr, reg_addr, reg_data, chram_q, colram_q, chrom_q,
        input  map_addr, chrom_addr
    );
endinterface

// File: rtl/charmap_renderer_regs.sv
// Shadow/active register file. CPU writes land in the shadow copy; the active copy
// reloads from shadow on the pixel edge where vblank rises, so scroll never tears mid-frame.
module charmap_regs
    import charmap_renderer_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        vblank_in,
    input  logic        reg_wr,
    input  logic [2:0]  reg_addr,
    input  logic [7:0]  reg_data,
    output logic [15:0] scroll_x,
    output logic [15:0] scroll_y,
    output logic [7:0]  bg_color,
    output logic        enable,
    output logic        bg_opaque
);

    logic [15:0] sh_scroll_x;
    logic [15:0] sh_scroll_y;
    logic [7:0]  sh_bg_color;
    logic [1:0]  sh_ctrl;
    logic        vblank_prev;
    logic        latch;

    assign latch = ce_pix && vblank_in && !vblank_prev;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sh_scroll_x <= '0;
            sh_scroll_y <= '0;
            sh_bg_color <= '0;
            sh_ctrl     <= '0;
            vblank_prev <= 1'b0;
            scroll_x    <= '0;
            scroll_y    <= '0;
            bg_color    <= '0;
            enable      <= 1'b0;
            bg_opaque   <= 1'b0;
        end else begin
            if (ce_pix)
                vblank_prev <= vblank_in;
            // Non-blocking reads give the pre-write shadow when a write shares the latch clock.
            if (latch) begin
                scroll_x  <= sh_scroll_x;
                scroll_y  <= sh_scroll_y;
                bg_color  <= sh_bg_color;
                enable    <= sh_ctrl[0];
                bg_opaque <= sh_ctrl[1];
            end
            if (reg_wr) begin
                case (reg_addr)
                    REG_SCROLL_X_LO: sh_scroll_x[7:0]  <= reg_data;
                    REG_SCROLL_X_HI: sh_scroll_x[15:8] <= reg_data;
                    REG_SCROLL_Y_LO: sh_scroll_y[7:0]  <= reg_data;
                    REG_SCROLL_Y_HI: sh_scroll_y[15:8] <= reg_data;
                    REG_BG_COLOR:    sh_bg_color       <= reg_data;
                    REG_CTRL:        sh_ctrl           <= reg_data[1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/charmap_renderer.sv
// Character-map renderer: raster counters plus scroll -> map fetch -> glyph fetch -> RGB888,
// three pixel-enable stages deep with sync/blank delayed alongside.
module charmap_renderer
    import charmap_renderer_pkg::*;
#(
    parameter int COLS_LOG2 = 6,
    parameter int ROWS_LOG2 = 5,
    parameter int CNT_W     = 9
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [CNT_W-1:0] hcnt,
    input  logic [CNT_W-1:0] vcnt,
    input  logic             hblank_in,
    input  logic             vblank_in,
    input  logic             hs_in,
    input  logic             vs_in,
    charmap_renderer_if.master bus,
    output logic [7:0]       rgb_r,
    output logic [7:0]       rgb_g,
    output logic [7:0]       rgb_b,
    output logic             hblank,
    output logic             vblank,
    output logic             hs,
    output logic             vs
);

    localparam int PX_W  = COLS_LOG2 + 3;
    localparam int PY_W  = ROWS_LOG2 + 3;
    localparam int MAP_W = COLS_LOG2 + ROWS_LOG2;

    logic [15:0]      scroll_x;
    logic [15:0]      scroll_y;
    logic [7:0]       bg_color;
    logic             enable;
    logic             bg_opaque;

    logic [PX_W-1:0]  px;
    logic [PY_W-1:0]  py;
    logic [MAP_W-1:0] map_addr_q;
    logic [2:0]       s1_fine_x;
    logic [2:0]       s1_fine_y;
    logic [10:0]      chrom_addr_q;
    logic [7:0]       s2_attr;
    logic [2:0]       s2_fine_x;
    logic [3:0]       sync_q [LATENCY];
    logic             pix;
    logic [23:0]      rgb_next;
    logic             unused_scroll_bits;

    charmap_regs u_regs (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce_pix    (ce_pix),
        .vblank_in (vblank_in),
        .reg_wr    (bus.reg_wr),
        .reg_addr  (bus.reg_addr),
        .reg_data  (bus.reg_data),
        .scroll_x  (scroll_x),
        .scroll_y  (scroll_y),
        .bg_color  (bg_color),
        .enable    (enable),
        .bg_opaque (bg_opaque)
    );

    // Map wrap-around is plain truncation to the map size in pixels.
    assign px = PX_W'(hcnt) + scroll_x[PX_W-1:0];
    assign py = PY_W'(vcnt) + scroll_y[PY_W-1:0];
    assign unused_scroll_bits = ^{scroll_x[15:PX_W], scroll_y[15:PY_W]};

    assign bus.map_addr   = map_addr_q;
    assign bus.chrom_addr = chrom_addr_q;

    always_comb begin
        rgb_next = '0;
        pix      = bus.chrom_q[3'd7 - s2_fine_x];
        if (enable && !(sync_q[LATENCY-2][3] || sync_q[LATENCY-2][2])) begin
            if (pix)
                rgb_next = attr_to_rgb(s2_attr);
            else if (bg_opaque)
                rgb_next = attr_to_rgb(bg_color);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            map_addr_q   <= '0;
            s1_fine_x    <= '0;
            s1_fine_y    <= '0;
            chrom_addr_q <= '0;
            s2_attr      <= '0;
            s2_fine_x    <= '0;
            rgb_r        <= '0;
            rgb_g        <= '0;
            rgb_b        <= '0;
            for (int i = 0; i < LATENCY; i++)
                sync_q[i] <= '0;
        end else if (ce_pix) begin
            map_addr_q   <= {py[PY_W-1:3], px[PX_W-1:3]};
            s1_fine_x    <= px[2:0];
            s1_fine_y    <= py[2:0];
            chrom_addr_q <= {bus.chram_q, s1_fine_y};
            s2_attr      <= bus.colram_q;
            s2_fine_x    <= s1_fine_x;
            {rgb_r, rgb_g, rgb_b} <= rgb_next;
            sync_q[0]    <= {hblank_in, vblank_in, hs_in, vs_in};
            for (int i = 1; i < LATENCY; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign {hblank, vblank, hs, vs} = sync_q[LATENCY-1];

endmodule

// File: tb/tb_charmap_renderer.sv
// Self-checking bench: directed literal probes plus randomized frames compared every clock
// against a pixel-level reference model of the renderer.
module tb_charmap_renderer;
    import charmap_renderer_pkg::*;

    localparam int COLS_LOG2 = 6;
    localparam int ROWS_LOG2 = 5;
    localparam int CNT_W     = 9;
    localparam int MAP_W     = COLS_LOG2 + ROWS_LOG2;
    localparam int PXN       = 1 << (COLS_LOG2 + 3);
    localparam int PYN       = 1 << (ROWS_LOG2 + 3);
    localparam int MAPC      = 1 << COLS_LOG2;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic             ce_pix;
    logic [CNT_W-1:0] hcnt, vcnt;
    logic             hblank_in, vblank_in, hs_in, vs_in;
    logic [7:0]       rgb_r, rgb_g, rgb_b;
    logic             hblank, vblank, hs, vs;

    charmap_renderer_if #(.MAP_W(MAP_W)) bus ();

    charmap_renderer #(.COLS_LOG2(COLS_LOG2), .ROWS_LOG2(ROWS_LOG2), .CNT_W(CNT_W)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce_pix    (ce_pix),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .hblank_in (hblank_in),
        .vblank_in (vblank_in),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .bus       (bus),
        .rgb_r     (rgb_r),
        .rgb_g     (rgb_g),
        .rgb_b     (rgb_b),
        .hblank    (hblank),
        .vblank    (vblank),
        .hs        (hs),
        .vs        (vs)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] chram  [2048];
    logic [7:0] colram [2048];
    logic [7:0] chrom  [2048];

    always @(posedge clk_sys) begin
        bus.chram_q  <= chram[bus.map_addr];
        bus.colram_q <= colram[bus.map_addr];
        bus.chrom_q  <= chrom[bus.chrom_addr];
    end

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    int gap_mode = 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit         pix;
        logic [7:0] attr;
        bit         blank;
        logic [3:0] sync;
    } samp_t;

    samp_t       q[$];
    samp_t       ms, md;
    logic [15:0] sh_sx, sh_sy, act_sx, act_sy;
    logic [7:0]  sh_bg, act_bg;
    logic [1:0]  sh_ctrl, act_ctrl;
    bit          m_prev_vb, m_latch, rgb_valid;
    logic [23:0] exp_rgb;
    logic [3:0]  exp_sync;
    logic [10:0] exp_map;
    int          mx, my, mcell;
    logic [7:0]  mch, mglyph;

    function automatic logic [23:0] expand(input logic [7:0] a);
        int r, g, b;
        r = (int'(a) % 8) * 36;
        g = ((int'(a) / 8) % 8) * 36;
        b = (int'(a) / 64) * 84;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    function automatic logic [23:0] pixel_colour(input samp_t s);
        if (!act_ctrl[0] || s.blank) return 24'h0;
        if (s.pix) return expand(s.attr);
        if (act_ctrl[1]) return expand(act_bg);
        return 24'h0;
    endfunction

    always @(posedge clk_sys) begin
        if (reset) begin
            sh_sx = 0; sh_sy = 0; sh_bg = 0; sh_ctrl = 0;
            act_sx = 0; act_sy = 0; act_bg = 0; act_ctrl = 0;
            m_prev_vb = 0;
            q.delete();
            exp_rgb = 0; exp_sync = 0; exp_map = 0;
            rgb_valid = 1;
        end else begin
            m_latch = 0;
            if (ce_pix) begin
                mx = (int'(hcnt) + int'(act_sx)) % PXN;
                my = (int'(vcnt) + int'(act_sy)) % PYN;
                mcell = (my / 8) * MAPC + mx / 8;
                mch = chram[mcell];
                mglyph = chrom[int'(mch) * 8 + my % 8];
                ms.pix = mglyph[7 - (mx % 8)];
                ms.attr = colram[mcell];
                ms.blank = hblank_in | vblank_in;
                ms.sync = {hblank_in, vblank_in, hs_in, vs_in};
                exp_map = 11'(mcell);
                q.push_back(ms);
                if (q.size() == 3) begin
                    md = q.pop_front();
                    exp_rgb = pixel_colour(md);
                    exp_sync = md.sync;
                    rgb_valid = 1;
                end else begin
                    rgb_valid = 0;
                end
                m_latch = vblank_in && !m_prev_vb;
                m_prev_vb = vblank_in;
            end
            if (m_latch) begin
                act_sx = sh_sx; act_sy = sh_sy; act_bg = sh_bg; act_ctrl = sh_ctrl;
            end
            if (bus.reg_wr) begin
                case (bus.reg_addr)
                    3'd0: sh_sx[7:0]  = bus.reg_data;
                    3'd1: sh_sx[15:8] = bus.reg_data;
                    3'd2: sh_sy[7:0]  = bus.reg_data;
                    3'd3: sh_sy[15:8] = bus.reg_data;
                    3'd4: sh_bg       = bus.reg_data;
                    3'd5: sh_ctrl     = bus.reg_data[1:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk_sys) begin
        if (chk_on) begin
            check("map_addr", 32'(bus.map_addr), 32'(exp_map));
            check("sync", 32'({hblank, vblank, hs, vs}), 32'(exp_sync));
            if (rgb_valid)
                check("rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'(exp_rgb));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input bit wr = 1'b0, input logic [2:0] a = 3'd0, input logic [7:0] d = 8'd0);
        @(negedge clk_sys);
        ce_pix = 1'b0;
        bus.reg_wr = wr; bus.reg_addr = a; bus.reg_data = d;
    endtask

    task automatic pixel(input int h, input int v, input bit hb, input bit vb,
                         input bit hsv = 1'b0, input bit vsv = 1'b0,
                         input bit wr = 1'b0, input logic [2:0] a = 3'd0, input logic [7:0] d = 8'd0);
        int g;
        @(negedge clk_sys);
        hcnt = CNT_W'(h); vcnt = CNT_W'(v);
        hblank_in = hb; vblank_in = vb; hs_in = hsv; vs_in = vsv;
        ce_pix = 1'b1;
        bus.reg_wr = wr; bus.reg_addr = a; bus.reg_data = d;
        g = (gap_mode == 0) ? int'($urandom_range(1, 2)) : gap_mode;
        repeat (g) tick();
    endtask

    task automatic wreg(input logic [2:0] a, input logic [7:0] d);
        tick(1'b1, a, d);
        tick();
    endtask

    task automatic latch_frame();
        pixel(0, 0, 1, 0);
        pixel(0, 0, 1, 1);
    endtask

    task automatic probe(input int h, input int v, input bit hb,
                         output logic [23:0] rgb, output logic [10:0] ma);
        pixel(h, v, hb, 0);
        ma = bus.map_addr;
        pixel(0, 0, 1, 0);
        pixel(0, 0, 1, 0);
        rgb = {rgb_r, rgb_g, rgb_b};
    endtask

    task automatic run_frame();
        int hoff, voff;
        bit wr;
        logic [2:0] a;
        logic [7:0] d;
        hoff = int'($urandom_range(0, 511));
        voff = int'($urandom_range(0, 511));
        for (int v = 0; v < 12; v++) begin
            for (int h = 0; h < 48; h++) begin
                wr = ($urandom_range(0, 15) == 0);
                a = 3'($urandom_range(0, 7));
                d = 8'($urandom);
                if (a == 3'd5) d[0] = ($urandom_range(0, 3) != 0);
                pixel((h + hoff) % 512, (v + voff) % 512, h >= 32, v >= 8,
                      (h >= 36) && (h < 40), v == 9, wr, a, d);
            end
        end
    endtask

    logic [23:0] rgb_s;
    logic [10:0] ma_s;

    initial begin
        reset = 1'b1; ce_pix = 1'b0;
        hcnt = '0; vcnt = '0; hblank_in = 0; vblank_in = 0; hs_in = 0; vs_in = 0;
        bus.reg_wr = 0; bus.reg_addr = 0; bus.reg_data = 0;
        for (int i = 0; i < 2048; i++) begin
            chram[i]  = 8'($urandom);
            colram[i] = 8'($urandom);
            chrom[i]  = 8'($urandom);
        end
        chram[0] = 8'h41; colram[0] = 8'h07;
        chrom[8'h41 * 8] = 8'h18;
        chram[64] = 8'h00;
        for (int i = 0; i < 8; i++) chrom[i] = 8'h00;

        tick();
        chk_on = 1'b1;
        tick(); tick();
        @(negedge clk_sys); reset = 1'b0;
        check("reset_rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'h0);
        check("reset_sync", 32'({hblank, vblank, hs, vs}), 32'h0);
        check("reset_map", 32'(bus.map_addr), 32'h0);

        // glyph 0x41, attr 0x07, row 0 = 0x18 -> pixels 3,4 lit red
        wreg(REG_CTRL, 8'h01);
        latch_frame();
        probe(3, 0, 0, rgb_s, ma_s);
        check("glyph_lit_h3", 32'(rgb_s), 32'hFC0000);
        probe(4, 0, 0, rgb_s, ma_s);
        check("glyph_lit_h4", 32'(rgb_s), 32'hFC0000);
        probe(0, 0, 0, rgb_s, ma_s);
        check("glyph_unlit_h0", 32'(rgb_s), 32'h0);

        wreg(REG_SCROLL_X_LO, 8'd3);
        latch_frame();
        probe(0, 0, 0, rgb_s, ma_s);
        check("scroll3_h0", 32'(rgb_s), 32'hFC0000);
        probe(2, 0, 0, rgb_s, ma_s);
        check("scroll3_h2", 32'(rgb_s), 32'h0);

        wreg(REG_SCROLL_X_LO, 8'hFF);
        wreg(REG_SCROLL_X_HI, 8'h01);
        latch_frame();
        probe(1, 8, 0, rgb_s, ma_s);
        check("wrap_map", 32'(ma_s), 32'd64);

        wreg(REG_SCROLL_X_LO, 8'h00);
        wreg(REG_SCROLL_X_HI, 8'h00);
        latch_frame();
        probe(3, 0, 0, rgb_s, ma_s);
        check("sy_base", 32'(rgb_s), 32'hFC0000);
        wreg(REG_SCROLL_Y_LO, 8'd8);
        probe(3, 0, 0, rgb_s, ma_s);
        check("sy_shadow_only", 32'(rgb_s), 32'hFC0000);
        pixel(0, 0, 1, 0);
        pixel(0, 0, 1, 1, 0, 0, 1'b1, REG_SCROLL_Y_LO, 8'd0);
        probe(3, 0, 0, rgb_s, ma_s);
        check("sy_latched_old", 32'(rgb_s), 32'h0);
        latch_frame();
        probe(3, 0, 0, rgb_s, ma_s);
        check("sy_next_latch", 32'(rgb_s), 32'hFC0000);

        wreg(REG_BG_COLOR, 8'hC0);
        wreg(REG_CTRL, 8'h03);
        latch_frame();
        probe(0, 0, 0, rgb_s, ma_s);
        check("bg_opaque", 32'(rgb_s), 32'h0000FC);
        probe(0, 0, 1, rgb_s, ma_s);
        check("blank_zero", 32'(rgb_s), 32'h0);

        pixel(0, 0, 0, 0);
        pixel(0, 0, 0, 0);
        pixel(100, 100, 0, 0);
        check("pre_reset_rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'h0000FC);
        @(negedge clk_sys); reset = 1'b1; ce_pix = 1'b1; hcnt = 9'd200;
        @(negedge clk_sys); reset = 1'b0; ce_pix = 1'b0;
        check("midreset_rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'h0);
        check("midreset_map", 32'(bus.map_addr), 32'h0);
        check("midreset_sync", 32'({hblank, vblank, hs, vs}), 32'h0);
        tick();

        for (int m = 0; m < 3; m++) begin
            gap_mode = (m == 0) ? 1 : (m == 1) ? 2 : 0;
            wreg(REG_CTRL, 8'($urandom_range(0, 1) * 2 + 1));
            wreg(REG_BG_COLOR, 8'($urandom));
            wreg(REG_SCROLL_X_LO, 8'($urandom));
            wreg(REG_SCROLL_Y_LO, 8'($urandom));
            for (int f = 0; f < 3; f++) run_frame();
        end

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
